calc_cmd_sequencer: RTL and testbench

Command sequencer between the keypad decoder and the calculator core. Buffers key codes in a small FIFO and issues them one at a time on the core's 4-bit cmd bus. Each issue follows the core's 2-bit status handshake (00 error, 01 busy, 10 ready). Detects core errors and stalled handshakes, flushes pending keys, and generates a one-cycle core reset on operator clear.

---
 rtl/calc_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_sequencer.sv
// Command sequencer between the keypad decoder and the calculator core.
// Buffers key codes in a small FIFO and issues them one at a time, following the
// core's status handshake; detects core errors and stalled handshakes.
module calc_cmd_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [3:0]  CMD_IDLE = 4'hD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic                     key_ready,
  input  logic                     clear_err,
  input  logic [1:0]               status_in,
  output logic [3:0]               cmd_out,
  output logic                     cmd_valid,
  output logic                     calc_rst,
  output logic                     err,
  output logic                     err_timeout,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  localparam logic [1:0] StatErr   = 2'b00;
  localparam logic [1:0] StatBusy  = 2'b01;
  localparam logic [1:0] StatReady = 2'b10;

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitReady, StError} state_e;

  state_e          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic [3:0]      cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            err_timeout_q, err_timeout_d;
  logic            calc_rst_q, calc_rst_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, flush;

  assign key_ready  = (count_q < CountFull) && (state_q != StError);
  assign push       = key_valid && key_ready;
  assign overflow_d = key_valid && (count_q == CountFull) && (state_q != StError);
  // Flush only on the edge that enters ERROR; pushes are blocked while in it.
  assign flush      = (state_d == StError) && (state_q != StError);
  // Saturating increment so the timer can never wrap back to zero.
  assign timer_inc  = (timer_q == TimerLast) ? timer_q : timer_q + TW'(1);

  // Next-state, handshake and command register logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = cmd_valid_q;
    err_timeout_d = err_timeout_q;
    calc_rst_d    = 1'b0;
    pop           = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_d       = CMD_IDLE;
        cmd_valid_d = 1'b0;
        if (status_in == StatReady && count_q != '0) begin
          pop         = 1'b1;
          cmd_d       = mem_q[rd_ptr_q];
          cmd_valid_d = 1'b1;
          timer_d     = '0;
          state_d     = StWaitBusy;
        end else if (status_in == StatErr) begin
          state_d       = StError;
          err_timeout_d = 1'b0;
        end
      end
      StWaitBusy: begin
        timer_d = timer_inc;
        if (status_in == StatErr) begin
          state_d       = StError;
          err_timeout_d = 1'b0;
          cmd_d         = CMD_IDLE;
          cmd_valid_d   = 1'b0;
        end else if (status_in == StatBusy) begin
          state_d     = StWaitReady;
          cmd_d       = CMD_IDLE;
          cmd_valid_d = 1'b0;
          timer_d     = '0;
        end else if (timer_q == TimerLast) begin
          state_d       = StError;
          err_timeout_d = 1'b1;
          cmd_d         = CMD_IDLE;
          cmd_valid_d   = 1'b0;
        end
      end
      StWaitReady: begin
        timer_d = timer_inc;
        if (status_in == StatErr) begin
          state_d       = StError;
          err_timeout_d = 1'b0;
        end else if (timer_q == TimerLast) begin
          state_d       = StError;
          err_timeout_d = 1'b1;
        end else if (status_in == StatReady) begin
          state_d = StIdle;
        end
      end
      StError: begin
        cmd_d       = CMD_IDLE;
        cmd_valid_d = 1'b0;
        if (clear_err) begin
          calc_rst_d    = 1'b1;
          err_timeout_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State machine and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      cmd_q         <= CMD_IDLE;
      cmd_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      calc_rst_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      err_timeout_q <= err_timeout_d;
      calc_rst_q    <= calc_rst_d;
      overflow_q    <= overflow_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= key_code;
  end

  assign cmd_out     = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign calc_rst    = calc_rst_q;
  assign err         = (state_q == StError);
  assign err_timeout = err_timeout_q;
  assign overflow    = overflow_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Self-checking bench for calc_cmd_sequencer: directed scenarios followed by random
// traffic, compared cycle by cycle against a queue-based reference model, with a
// scoreboard that matches every issued command against the model's issue order.
module tb_calc_cmd_sequencer;

  localparam int         DEPTH    = 4;
  localparam int         TIMEOUT  = 64;
  localparam logic [3:0] CMD_IDLE = 4'hD;

  localparam int MIdle  = 0;
  localparam int MBusy  = 1;
  localparam int MReady = 2;
  localparam int MErr   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_ready;
  logic       clear_err = 1'b0;
  logic [1:0] status_in = 2'b10;
  logic [3:0] cmd_out;
  logic       cmd_valid;
  logic       calc_rst;
  logic       err;
  logic       err_timeout;
  logic       overflow;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_mode, m_timer, m_cmd;
  bit m_valid, m_rst, m_to, m_ovf, m_entered;
  int fifo[$];
  int exp_q[$];

  calc_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CMD_IDLE(CMD_IDLE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .clear_err  (clear_err),
    .status_in  (status_in),
    .cmd_out    (cmd_out),
    .cmd_valid  (cmd_valid),
    .calc_rst   (calc_rst),
    .err        (err),
    .err_timeout(err_timeout),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    fifo.delete();
    m_mode  = MIdle;
    m_timer = 0;
    m_cmd   = CMD_IDLE;
    m_valid = 0;
    m_rst   = 0;
    m_to    = 0;
    m_ovf   = 0;
  endtask

  task automatic raise_err(input bit to);
    m_mode    = MErr;
    m_to      = to;
    m_cmd     = CMD_IDLE;
    m_valid   = 0;
    m_entered = 1;
  endtask

  // One clock edge of the reference behaviour, from the inputs about to be sampled.
  task automatic model_step(input bit kv, input int kc, input bit ce, input int st,
                            input bit rst);
    bit do_push;
    if (rst) begin
      model_reset();
      return;
    end
    do_push   = kv && fifo.size() < DEPTH && m_mode != MErr;
    m_ovf     = kv && fifo.size() == DEPTH && m_mode != MErr;
    m_rst     = 0;
    m_entered = 0;
    case (m_mode)
      MIdle: begin
        if (st == 2 && fifo.size() > 0) begin
          m_cmd   = fifo.pop_front();
          m_valid = 1;
          m_timer = 0;
          m_mode  = MBusy;
          exp_q.push_back(m_cmd);
        end else if (st == 0) raise_err(0);
      end
      MBusy: begin
        if (st == 0) raise_err(0);
        else if (st == 1) begin
          m_mode  = MReady;
          m_cmd   = CMD_IDLE;
          m_valid = 0;
          m_timer = 0;
        end else if (m_timer == TIMEOUT - 1) raise_err(1);
        else m_timer++;
      end
      MReady: begin
        if (st == 0) raise_err(0);
        else if (m_timer == TIMEOUT - 1) raise_err(1);
        else if (st == 2) m_mode = MIdle;
        else m_timer++;
      end
      default: begin
        if (ce) begin
          m_mode = MIdle;
          m_rst  = 1;
          m_to   = 0;
        end
      end
    endcase
    if (do_push) fifo.push_back(kc);
    if (m_entered) fifo.delete();
  endtask

  // Drive one cycle of inputs, advance the model and compare every output.
  task automatic step(input bit kv, input int kc, input bit ce, input int st, input bit rst);
    @(negedge clock);
    key_valid = kv;
    key_code  = 4'(kc);
    clear_err = ce;
    status_in = 2'(st);
    reset     = rst;
    #1;
    chk("key_ready", int'(key_ready), int'(fifo.size() < DEPTH && m_mode != MErr));
    model_step(kv, kc, ce, st, rst);
    @(posedge clock);
    #1;
    chk("cmd_out", int'(cmd_out), m_cmd);
    chk("cmd_valid", int'(cmd_valid), int'(m_valid));
    chk("calc_rst", int'(calc_rst), int'(m_rst));
    chk("err", int'(err), int'(m_mode == MErr));
    chk("err_timeout", int'(err_timeout), int'(m_to));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("fifo_count", int'(fifo_count), fifo.size());
  endtask

  // Scoreboard monitor: each new command on the bus must match the model's next issue.
  initial begin
    bit prev_v = 0;
    int exp;
    forever begin
      @(negedge clock);
      if (cmd_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", int'(cmd_out), -1);
        end else begin
          exp = exp_q.pop_front();
          chk("issued_cmd", int'(cmd_out), exp);
        end
      end
      prev_v = cmd_valid;
    end
  end

  initial begin
    model_reset();
    step(0, 0, 0, 2, 1);
    step(0, 0, 0, 2, 1);
    chk("rst_cmd_out", int'(cmd_out), 13);
    chk("rst_fifo_count", int'(fifo_count), 0);

    // Basic issue and handshake.
    step(1, 5, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    chk("basic_cmd", int'(cmd_out), 5);
    chk("basic_valid", int'(cmd_valid), 1);
    step(0, 0, 0, 1, 0);
    chk("basic_valid_fall", int'(cmd_valid), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 2, 0);

    // Ordering and overflow.
    step(1, 1, 0, 1, 0);
    step(1, 2, 0, 1, 0);
    step(1, 10, 0, 1, 0);
    step(1, 3, 0, 1, 0);
    step(1, 14, 0, 1, 0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("full_count", int'(fifo_count), 4);
    step(0, 0, 0, 1, 0);
    chk("ovf_clear", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 2, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 2, 0);
    end
    chk("drained", int'(fifo_count), 0);

    // Simultaneous push and pop.
    step(1, 8, 0, 1, 0);
    step(1, 9, 0, 1, 0);
    step(1, 7, 0, 2, 0);
    chk("pushpop_count", int'(fifo_count), 2);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 2, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 2, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 2, 0);
    end

    // Timeout in WAIT_BUSY, with keys arriving during the wait.
    step(1, 4, 0, 1, 0);
    step(0, 0, 0, 2, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      step(i < 3, 11, 0, 2, 0);
      if (i == TIMEOUT - 2) chk("to_not_yet", int'(err), 0);
    end
    chk("to_err", int'(err), 1);
    chk("to_cause", int'(err_timeout), 1);
    chk("to_flushed", int'(fifo_count), 0);
    chk("to_key_ready", int'(key_ready), 0);
    step(0, 0, 1, 2, 0);
    chk("to_clear_rst", int'(calc_rst), 1);
    step(0, 0, 0, 1, 0);
    chk("to_rst_one_cycle", int'(calc_rst), 0);

    // Core error during WAIT_READY with three keys buffered.
    step(1, 6, 0, 1, 0);
    step(0, 0, 0, 2, 0);
    step(1, 1, 0, 1, 0);
    step(1, 2, 0, 1, 0);
    step(1, 3, 0, 1, 0);
    chk("cerr_buffered", int'(fifo_count), 3);
    step(0, 0, 0, 0, 0);
    chk("cerr_err", int'(err), 1);
    chk("cerr_cause", int'(err_timeout), 0);
    chk("cerr_flushed", int'(fifo_count), 0);
    step(1, 9, 0, 1, 0);
    chk("cerr_no_ovf", int'(overflow), 0);
    step(0, 0, 1, 1, 0);
    chk("cerr_calc_rst", int'(calc_rst), 1);
    chk("cerr_err_clr", int'(err), 0);
    step(0, 0, 1, 1, 0);
    chk("clear_ignored", int'(calc_rst), 0);

    // Reset in WAIT_BUSY with two keys buffered.
    step(1, 10, 0, 1, 0);
    step(1, 11, 0, 1, 0);
    step(1, 12, 0, 1, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 1);
    chk("mrst_cmd_out", int'(cmd_out), 13);
    chk("mrst_valid", int'(cmd_valid), 0);
    chk("mrst_count", int'(fifo_count), 0);
    step(0, 0, 0, 2, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r, st;
      r  = $urandom_range(0, 99);
      st = (r < 3) ? 0 : (r < 50) ? 1 : 2;
      step($urandom_range(0, 9) < 4, $urandom_range(0, 15), $urandom_range(0, 4) == 0, st,
           $urandom_range(0, 199) == 0);
    end

    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
